seq_signed_divider: RTL and testbench
=====================================

# seq_signed_divider

Multi-cycle signed radix-2 divider for the arithmetic lab datapath. It is the inverse of the 32x32 signed array multiplier: it takes a 2W-bit signed dividend (a full product width) and a W-bit signed divisor. It returns a W-bit quotient and a W-bit remainder after a fixed-latency restoring iteration on magnitudes. Control is a start/done pulse handshake, so a multiplier product can be fed back directly for round-trip checking.

## Interface
- W, default 32, operand width; dividend is 2W bits, quotient/remainder W bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- dividend  in  2W  signed dividend, two's complement; sampled with start.
- divisor  in  W  signed divisor; sampled with start.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high (exclusive).
- done  out  1  one-cycle pulse; results valid in the same cycle.
- quotient  out  W  signed quotient, held until next done.
- remainder  out  W  signed remainder, held until next done.
- ovf  out  1  quotient not representable in W signed bits.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, DIV, FIX.
- IDLE:
  - start=1 latches |dividend| (2W-bit unsigned), |divisor| (W-bit unsigned), sign of dividend and sign of divisor.
  - Clears the partial remainder (W+1 bits) and the iteration counter.
  - Next state is DIV, or FIX when divisor=0 and DIVZ_FAST_EN is defined.
- DIV, one quotient bit per cycle, 2W cycles total:
  - Shift the MSB of the dividend register into the partial remainder.
  - Trial-subtract |divisor|.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter reaching 2W-1 moves the state to FIX.
- FIX, one cycle:
  - Apply signs. Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Truncation is toward zero (C semantics).
  - ovf=1 when the signed 2W-bit quotient lies outside [-2^(W-1), 2^(W-1)-1].
  - Register the outputs, set done=1, and return to IDLE.
- Error results:
  - ovf=1: quotient=0, remainder=0, dbz=0.
  - dbz=1: quotient=0, remainder=0, ovf=0.
- Magnitude of -2^(2W-1) is 2^(2W-1), which fits the unsigned register, so no special case is needed. The remainder magnitude is always < 2^(W-1) when no error is flagged.
- start while busy=1 is ignored and has no side effects.
- start asserted in the same cycle as done is accepted, because the state is already IDLE.
- rst=1 at any edge:
  - State goes to IDLE and the in-flight operation is discarded with no done.
  - quotient, remainder, ovf and dbz clear to 0.
  - busy=0, done=0.

## Timing
- Start accepted at edge k. busy=1 from after edge k.
- Nominal path: done=1 after edge k+2W+1. Latency is 2W+2 edges, i.e. 66 for W=32. busy drops in the same cycle that done rises.
- Divide-by-zero with DIVZ_FAST_EN defined: done after edge k+1 (2 edges).
- Throughput: one operation every 2W+2 cycles with back-to-back start.
- Outputs change only on the done edge or on reset.

## Configuration
- DIVZ_FAST_EN defined: zero divisor bypasses DIV; latency is 2 edges.
- DIVZ_FAST_EN undefined: zero divisor runs the full 2W iterations. FIX forces the dbz results, so outputs are identical and only latency differs (2W+2).

## Test plan
- dividend=100, divisor=7 -> done exactly 66 edges after start; quotient=14, remainder=2, ovf=0, dbz=0.
- Sign cases, each expected with ovf=0:
  - dividend=-100, divisor=7 -> quotient=-14, remainder=-2.
  - dividend=100, divisor=-7 -> quotient=-14, remainder=2.
- Multiplier round trip:
  - dividend=0x7FFFFFFF*(-2^31)=0xC000000080000000, divisor=0x80000000 -> quotient=0x7FFFFFFF, remainder=0.
  - dividend=-2^31, divisor=1 -> quotient=0x80000000, ovf=0.
- Overflow:
  - dividend=2^32, divisor=1 -> ovf=1, quotient=0, remainder=0.
  - dividend=-2^31, divisor=-1 -> ovf=1.
- Divisor=0, dividend=5 -> dbz=1, quotient=0, remainder=0. Latency is 2 edges with DIVZ_FAST_EN, 66 without.
- Handshake and reset:
  - start pulsed at edge 10 of an operation -> ignored, result unchanged.
  - rst at edge 30 -> no done, outputs 0, busy=0.
  - New start the next cycle completes normally in 66 edges.

Source files
------------

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Optional macro DIVZ_FAST_EN: a zero divisor skips the iteration phase (2-edge latency instead of 2W+2).
module seq_signed_divider #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz,
  output logic [1:0]     state_dbg
);

  // Handshake: start is sampled only while busy=0; done is a one-cycle pulse with results valid in that cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, FIX = 2'd2} state_t;

  localparam int CW = $clog2(2*W);
  localparam logic [CW-1:0]  LAST    = CW'(2*W-1);
  localparam logic [2*W-1:0] LIM_NEG = (2*W)'(1) << (W-1);
  localparam logic [2*W-1:0] LIM_POS = LIM_NEG - (2*W)'(1);

  state_t         state;
  logic [2*W-1:0] dvd_r;
  logic [W-1:0]   dvs_r;
  logic [W-1:0]   rem_r;
  logic [CW-1:0]  cnt;
  logic           sign_n, sign_d, zero_d;

  logic [2*W-1:0] dvd_abs;
  logic [W-1:0]   dvs_abs;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic           ge;
  logic           q_neg, q_ovf;
  logic [W-1:0]   q_signed, r_signed;

  // The partial remainder stays below |divisor| <= 2^(W-1), so the top bit of diff is a valid borrow.
  always_comb begin
    dvd_abs  = dividend[2*W-1] ? -dividend : dividend;
    dvs_abs  = divisor[W-1] ? -divisor : divisor;
    shifted  = {rem_r, dvd_r[2*W-1]};
    diff     = shifted - {1'b0, dvs_r};
    ge       = ~diff[W];
    q_neg    = sign_n ^ sign_d;
    q_ovf    = q_neg ? (dvd_r > LIM_NEG) : (dvd_r > LIM_POS);
    q_signed = q_neg ? -dvd_r[W-1:0] : dvd_r[W-1:0];
    r_signed = sign_n ? -rem_r : rem_r;
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      cnt       <= '0;
      sign_n    <= 1'b0;
      sign_d    <= 1'b0;
      zero_d    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r  <= dvd_abs;
            dvs_r  <= dvs_abs;
            sign_n <= dividend[2*W-1];
            sign_d <= divisor[W-1];
            zero_d <= (divisor == '0);
            rem_r  <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef DIVZ_FAST_EN
            state  <= (divisor == '0) ? FIX : DIV;
`else
            state  <= DIV;
`endif
          end
        end
        DIV: begin
          // Quotient bits shift into the vacated LSBs of the dividend register.
          rem_r <= ge ? diff[W-1:0] : shifted[W-1:0];
          dvd_r <= {dvd_r[2*W-2:0], ge};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (zero_d) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b1;
          end else if (q_ovf) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b1;
            dbz       <= 1'b0;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (W=32): directed, random, handshake and reset scenarios.
module tb_seq_signed_divider;

  localparam int W   = 32;
  localparam int LAT = 2*W + 2;
`ifdef DIVZ_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 2*W + 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   dividend = '0;
  logic [31:0]   divisor = '0;
  logic          busy, done, ovf, dbz;
  logic [31:0]   quotient, remainder;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference: C-style truncating division on magnitudes using plain 64-bit arithmetic.
  function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic o, output logic z);
    logic [63:0] bs, am, bm, qm, rm, qs, rs;
    logic qn;
    bs = {{32{b[31]}}, b};
    am = a[63] ? -a : a;
    bm = bs[63] ? -bs : bs;
    q = '0; r = '0; o = 1'b0; z = 1'b0;
    if (b == 32'd0) begin
      z = 1'b1;
    end else begin
      qm = am / bm;
      rm = am % bm;
      qn = a[63] ^ b[31];
      o  = qn ? (qm > 64'h0000_0000_8000_0000) : (qm > 64'h0000_0000_7FFF_FFFF);
      if (!o) begin
        qs = qn ? -qm : qm;
        rs = a[63] ? -rm : rm;
        q  = qs[31:0];
        r  = rs[31:0];
      end
    end
  endfunction

  // Drives start from the current point (just after an edge), waits for done and checks latency and results.
  task automatic run_op(input logic [63:0] a, input logic [31:0] b, input string name);
    logic [31:0] eq, er;
    logic eo, ez;
    int n, exp_lat;
    model(a, b, eq, er, eo, ez);
    exp_lat = (b == 32'd0) ? ZLAT : LAT;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: no done after %0d edges", name, n);
    end else begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d edges want %0d", name, n, exp_lat);
      end
      checks++;
      if ({quotient, remainder, ovf, dbz} !== {eq, er, eo, ez}) begin
        errors++;
        $display("FAIL %s result: got q=%h r=%h ovf=%b dbz=%b want q=%h r=%h ovf=%b dbz=%b",
                 name, quotient, remainder, ovf, dbz, eq, er, eo, ez);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_at_done: got %b want 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, ovf, dbz} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b want all 0",
               busy, done, quotient, remainder, ovf, dbz);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(64'd100, 32'd7, "pos_pos");
    run_op(-64'sd100, 32'd7, "neg_pos");
    run_op(64'd100, -32'sd7, "pos_neg");
    run_op(64'hC000_0000_8000_0000, 32'h8000_0000, "round_trip_min");
    run_op(-64'sd2147483648, 32'd1, "min_by_one");
    run_op(64'h0000_0001_0000_0000, 32'd1, "ovf_pos");
    run_op(-64'sd2147483648, 32'hFFFF_FFFF, "ovf_min_by_m1");
    run_op(64'd5, 32'd0, "div_by_zero");
    run_op(64'h8000_0000_0000_0000, 32'h8000_0000, "min_dividend");
    run_op(64'd0, 32'd9, "zero_dividend");
  endtask

  task automatic test_hold();
    run_op(-64'sd1000, 32'd33, "hold_op");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({done, quotient, remainder} !== {1'b0, -32'sd30, -32'sd10}) begin
      errors++;
      $display("FAIL hold: got done=%b q=%h r=%h want done=0 q=%h r=%h",
               done, quotient, remainder, -32'sd30, -32'sd10);
    end
  endtask

  task automatic test_random();
    logic [31:0] x, b;
    logic signed [63:0] xs, bs, p;
    logic [63:0] a;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = {{32{x[31]}}, x};
        1: begin
          xs = {{32{x[31]}}, x};
          bs = {{32{b[31]}}, b};
          p  = xs * bs;
          a  = p + 64'($urandom_range(0, 5));
        end
        2: a = {$urandom, $urandom};
        default: begin
          a = {{32{x[31]}}, x};
          b = 32'($signed($urandom_range(0, 8)) - 4);
        end
      endcase
      run_op(a, b, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_ignore_start();
    int n, extra;
    dividend = 64'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 9) begin
      @(posedge clk); #1;
      n++;
    end
    dividend = 64'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n++;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != LAT) begin
      errors++;
      $display("FAIL ignore_latency: done=%b after %0d edges want done=1 at %0d", done, n, LAT);
    end
    checks++;
    if ({quotient, remainder, ovf, dbz} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result: got q=%h r=%h ovf=%b dbz=%b want q=e r=2 ovf=0 dbz=0",
               quotient, remainder, ovf, dbz);
    end
    extra = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_no_second_done: got %0d extra done pulses want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int n, stray;
    run_op(64'd100, 32'd7, "pre_reset_op");
    dividend = -64'sd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 29) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, ovf, dbz} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b want all 0",
               busy, done, quotient, remainder, ovf, dbz);
    end
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_discard: got %0d cycles with done/busy want 0", stray);
    end
    run_op(64'd100, 32'd7, "post_reset_op");
  endtask

  task automatic test_back_to_back();
    run_op(64'd12345, 32'd10, "b2b_first");
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start_on_done: got done=%b want 1", done);
    end
    run_op(-64'sd12345, -32'sd10, "b2b_second");
    run_op(64'd77, 32'd0, "b2b_third_dbz");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
